// File: rtl/tx_module_if.sv
// tx_module_if: request/data inputs and serial line/status outputs of the UART transmitter.
interface tx_module_if;
    logic       TX_En_Sig;
    logic       Cmd_Mode;
    logic [7:0] TX_Data;
    logic [3:0] Set;
    logic [1:0] Type;
    logic       TX_Pin_Out;
    logic       TX_Busy;
    logic       TX_Done_Sig;
    modport master(output TX_En_Sig, Cmd_Mode, TX_Data, Set, Type, input TX_Pin_Out, TX_Busy, TX_Done_Sig);
    modport slave(input TX_En_Sig, Cmd_Mode, TX_Data, Set, Type, output TX_Pin_Out, TX_Busy, TX_Done_Sig);
endinterface

// File: rtl/tx_module.sv
// tx_module: 8N1 UART transmitter, raw byte or byte packed from Set/Type.
module tx_module #(
    parameter int BPS_DIV = 5208
) (
    input logic       CLK,
    input logic       RSTn,
    tx_module_if.slave tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [12:0] LAST = 13'(BPS_DIV - 1);
    state_t      state;
    logic [12:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        pin, busy, done;
    logic [7:0]  pack_byte, sel_byte;
    logic        tick;
    assign pack_byte = {2'b00, tx.Set[0], tx.Set[1], tx.Set[2], tx.Set[3], tx.Type[0], tx.Type[1]};
    assign sel_byte  = tx.Cmd_Mode ? pack_byte : tx.TX_Data;
    assign tick      = baud_cnt == LAST;
    assign tx.TX_Pin_Out  = pin;
    assign tx.TX_Busy     = busy;
    assign tx.TX_Done_Sig = done;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            pin       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            baud_cnt <= (state == IDLE || tick) ? 13'd0 : baud_cnt + 13'd1;
            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (tx.TX_En_Sig) begin
                        shift_reg <= sel_byte;
                        state     <= START;
                        pin       <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: if (tick) begin
                    state     <= DATA;
                    pin       <= shift_reg[0];
                    shift_reg <= {1'b0, shift_reg[7:1]};
                end
                DATA: if (tick) begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        pin   <= 1'b1;
                    end else begin
                        pin       <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end
                end
                STOP: if (tick) begin
                    done <= 1'b1;
                    // a request on the closing edge chains the next start bit with no idle gap
                    if (tx.TX_En_Sig) begin
                        shift_reg <= sel_byte;
                        state     <= START;
                        pin       <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pin   <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_module.sv
// tb_tx_module: scoreboard bench; stimulus queues expected frames, a line monitor decodes and checks them.
module tb_tx_module;
    localparam int B = 4;
    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic rst2_n = 1'b0;
    always #5 CLK = ~CLK;
    tx_module_if bus();
    tx_module_if bus2();
    tx_module #(.BPS_DIV(B)) dut(.CLK(CLK), .RSTn(RSTn), .tx(bus));
    tx_module dut2(.CLK(CLK), .RSTn(rst2_n), .tx(bus2));
    typedef struct {
        logic [7:0] b;
        int         start;
        bit         abort;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (bus.TX_Done_Sig === 1'b1) n_done++;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic send(bit mode, logic [7:0] d, logic [3:0] s, logic [1:0] t, logic [7:0] exp_b, bit ab);
        @(negedge CLK);
        bus.Cmd_Mode = mode;
        bus.TX_Data = d;
        bus.Set = s;
        bus.Type = t;
        bus.TX_En_Sig = 1'b1;
        q.push_back('{exp_b, cyc + 1, ab});
        @(negedge CLK);
        bus.TX_En_Sig = 1'b0;
    endtask
    initial begin : mon
        logic [9:0] bits;
        bit stable, ab, have;
        int s;
        exp_t e;
        have = 0;
        forever begin
            if (!have) @(negedge CLK);
            have = 0;
            if (RSTn && bus.TX_Pin_Out === 1'b0) begin
                s = cyc;
                stable = 1;
                ab = 0;
                bits = '0;
                for (int n = 0; n < 10; n++)
                    for (int j = 0; j < B; j++)
                        if (!ab) begin
                            if (n != 0 || j != 0) @(negedge CLK);
                            if (!RSTn) ab = 1;
                            else if (j == 0) bits[n] = bus.TX_Pin_Out;
                            else if (bus.TX_Pin_Out !== bits[n]) stable = 0;
                        end
                if (q.size() == 0) begin
                    chk("unexpected_frame_start", s, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("abort", ab, e.abort);
                    if (!ab) begin
                        chk("start_cycle", s, e.start);
                        chk("start_bit", bits[0], 1'b0);
                        chk("stop_bit", bits[9], 1'b1);
                        chk("data", bits[8:1], e.b);
                        chk("bit_stable", stable, 1);
                        @(negedge CLK);
                        chk("done_pulse", bus.TX_Done_Sig, 1'b1);
                        have = RSTn && bus.TX_Pin_Out === 1'b0;
                    end
                end
            end
        end
    end
    initial begin
        bus.TX_En_Sig = 0;
        bus.Cmd_Mode = 0;
        bus.TX_Data = 0;
        bus.Set = 0;
        bus.Type = 0;
        bus2.TX_En_Sig = 0;
        bus2.Cmd_Mode = 0;
        bus2.TX_Data = 0;
        bus2.Set = 0;
        bus2.Type = 0;
        fork
            begin
                repeat (3) @(negedge CLK);
                chk("rst_pin", bus.TX_Pin_Out, 1'b1);
                chk("rst_busy", bus.TX_Busy, 1'b0);
                chk("rst_done", bus.TX_Done_Sig, 1'b0);
                RSTn = 1'b1;
                repeat (2) @(negedge CLK);
                send(0, 8'h55, 4'h0, 2'b00, 8'h55, 0);
                repeat (45) @(negedge CLK);
                send(1, 8'hFF, 4'b1010, 2'b01, 8'h16, 0);
                repeat (45) @(negedge CLK);
                send(1, 8'h00, 4'b0111, 2'b10, 8'h39, 0);
                repeat (45) @(negedge CLK);
                // new request with different data at k+10 must be ignored
                send(0, 8'h33, 4'h0, 2'b00, 8'h33, 0);
                repeat (9) @(negedge CLK);
                chk("busy_mid_frame", bus.TX_Busy, 1'b1);
                bus.TX_Data = 8'hFF;
                bus.Cmd_Mode = 1'b1;
                bus.Set = 4'hF;
                bus.Type = 2'b11;
                bus.TX_En_Sig = 1'b1;
                @(negedge CLK);
                bus.TX_En_Sig = 1'b0;
                repeat (40) @(negedge CLK);
                // held request: back-to-back frames
                @(negedge CLK);
                bus.Cmd_Mode = 1'b0;
                bus.TX_Data = 8'hA5;
                bus.TX_En_Sig = 1'b1;
                q.push_back('{8'hA5, cyc + 1, 1'b0});
                q.push_back('{8'h3C, cyc + 1 + 10 * B, 1'b0});
                repeat (20) @(negedge CLK);
                bus.TX_Data = 8'h3C;
                repeat (40) @(negedge CLK);
                bus.TX_En_Sig = 1'b0;
                repeat (30) @(negedge CLK);
                // reset mid-frame at k+17
                send(0, 8'h96, 4'h0, 2'b00, 8'h96, 1);
                repeat (16) @(negedge CLK);
                @(posedge CLK);
                #2 RSTn = 1'b0;
                #1;
                chk("abort_pin", bus.TX_Pin_Out, 1'b1);
                chk("abort_busy", bus.TX_Busy, 1'b0);
                chk("abort_done", bus.TX_Done_Sig, 1'b0);
                @(negedge CLK);
                #1 RSTn = 1'b1;
                repeat (3) @(negedge CLK);
                send(0, 8'hC3, 4'h0, 2'b00, 8'hC3, 0);
                repeat (45) @(negedge CLK);
            end
            begin : big
                int busy_cnt, low_cnt, d2;
                busy_cnt = 0;
                low_cnt = 0;
                d2 = 0;
                repeat (3) @(negedge CLK);
                rst2_n = 1'b1;
                @(negedge CLK);
                bus2.TX_En_Sig = 1'b1;
                @(negedge CLK);
                bus2.TX_En_Sig = 1'b0;
                for (int i = 0; i < 60000; i++) begin
                    if (bus2.TX_Done_Sig === 1'b1) begin
                        d2++;
                        break;
                    end
                    if (bus2.TX_Busy === 1'b1) busy_cnt++;
                    if (bus2.TX_Pin_Out === 1'b0) low_cnt++;
                    @(negedge CLK);
                end
                chk("big_done_seen", d2, 1);
                chk("big_frame_clocks", busy_cnt, 52080);
                chk("big_low_clocks", low_cnt, 46872);
            end
        join
        repeat (5) @(negedge CLK);
        chk("queue_empty", q.size(), 0);
        chk("done_count", n_done, 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
